// File: rtl/custom_axi_ip_arbiter.sv
// rtl/custom_axi_ip_arbiter.sv - round-robin arbiter sharing one custom_axi_ip engine between requesters
//
// custom_axi_ip_pkg: engine status encoding seen on eng_status_i.
// custom_axi_ip_arbiter ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   req_i, req_data_i          per-requester request and operand (held until gnt_o)
//   gnt_o                      one-hot single-cycle acceptance pulse
//   rsp_valid_o, rsp_id_o,
//   rsp_data_o, rsp_err_o      single-cycle tagged response (data 0 on error)
//   busy_o                     high whenever a transaction is in flight
//   eng_data_o, eng_enable_o   operand and start strobe towards the engine
//   eng_result_i, eng_status_i engine result and status

package custom_axi_ip_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } status_e;
endpackage

module custom_axi_ip_arbiter
  import custom_axi_ip_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          rsp_valid_o,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_err_o,
  output logic                          busy_o,
  output logic [DATA_WIDTH-1:0]         eng_data_o,
  output logic                          eng_enable_o,
  input  logic [DATA_WIDTH-1:0]         eng_result_i,
  input  status_e                       eng_status_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    A_IDLE    = 3'd0,
    A_ISSUE   = 3'd1,
    A_WAIT    = 3'd2,
    A_CAPTURE = 3'd3,
    A_RESP    = 3'd4
  } arb_state_e;

  arb_state_e              state_q;
  logic [ID_W-1:0]         ptr_q;
  logic [ID_W-1:0]         id_q;
  logic                    err_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic                    rsp_valid_q;
  logic [ID_W-1:0]         rsp_id_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_err_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   eng_data_q;
  logic                    eng_enable_q;

  logic [DATA_WIDTH-1:0]   req_data_a [NUM_REQ];
  logic                    win_found;
  logic [ID_W-1:0]         win_idx;
  int                      cand;
  logic [NUM_REQ-1:0]      gnt_d;
  logic [ID_W-1:0]         ptr_d;
  logic [CNT_W-1:0]        cnt_d;
  logic                    timeout;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data_a[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_i[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign gnt_d   = NUM_REQ'(1) << win_idx;
  assign ptr_d   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  // Saturates at the limit; the FSM leaves A_WAIT once the limit is reached.
  assign cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign timeout = (cnt_q >= CNT_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= A_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      eng_data_q   <= '0;
      eng_enable_q <= 1'b0;
    end else begin
      // Strobes default low; response fields only carry data in A_RESP.
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        A_IDLE: begin
          if (win_found) begin
            gnt_q      <= gnt_d;
            eng_data_q <= req_data_a[win_idx];
            id_q       <= win_idx;
            ptr_q      <= ptr_d;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= A_ISSUE;
          end
        end
        A_ISSUE: begin
          cnt_q <= cnt_d;
          if (eng_status_i == ERROR || (eng_status_i == IDLE && timeout)) begin
            eng_enable_q <= 1'b0;
            err_q        <= 1'b1;
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= id_q;
            rsp_err_q    <= 1'b1;
            state_q      <= A_RESP;
          end else if (eng_status_i != IDLE) begin
            eng_enable_q <= 1'b0;
            state_q      <= A_WAIT;
          end else begin
            eng_enable_q <= 1'b1;
          end
        end
        A_WAIT: begin
          cnt_q <= cnt_d;
          // DONE is tested first so it beats a coincident timeout.
          if (eng_status_i == DONE) begin
            state_q <= A_CAPTURE;
          end else if (eng_status_i == ERROR || timeout) begin
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_err_q   <= 1'b1;
            state_q     <= A_RESP;
          end
        end
        A_CAPTURE: begin
          // The engine registers its result while showing DONE, so it is
          // valid only here, one cycle later.
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_data_q  <= eng_result_i;
          rsp_err_q   <= 1'b0;
          state_q     <= A_RESP;
        end
        A_RESP: begin
          busy_q  <= 1'b0;
          state_q <= A_IDLE;
        end
        default: begin
          busy_q       <= 1'b0;
          eng_enable_q <= 1'b0;
          state_q      <= A_IDLE;
        end
      endcase
    end
  end

  assign gnt_o        = gnt_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = busy_q;
  assign eng_data_o   = eng_data_q;
  assign eng_enable_o = eng_enable_q;

endmodule

// File: tb/tb_custom_axi_ip_arbiter.sv
// tb/tb_custom_axi_ip_arbiter.sv - scoreboard bench for custom_axi_ip_arbiter with a behavioural engine
module tb_custom_axi_ip_arbiter;
  import custom_axi_ip_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;
  logic [W-1:0]   eng_data;
  logic           eng_enable;
  logic [W-1:0]   eng_result = '0;
  status_e        eng_status = IDLE;

  custom_axi_ip_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(req_data),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .busy_o(busy), .eng_data_o(eng_data), .eng_enable_o(eng_enable),
    .eng_result_i(eng_result), .eng_status_i(eng_status)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Engine model: mode 0 completes after eng_lat BUSY cycles, mode 1 sticks
  // in BUSY, mode 2 reports ERROR instead of DONE. Result = operand + 1.
  int         eng_mode = 0;
  int         eng_lat  = 2;
  int         bcnt     = 0;
  logic [W-1:0] eng_op = '0;
  always @(negedge clk) begin
    if (rst) begin
      eng_status = IDLE;
      eng_result = '0;
    end else begin
      case (eng_status)
        IDLE: if (eng_enable) begin
          eng_op     = eng_data;
          bcnt       = eng_lat;
          eng_status = BUSY;
        end
        BUSY: if (eng_mode != 1) begin
          if (bcnt == 0) eng_status = (eng_mode == 2) ? ERROR : DONE;
          else bcnt--;
        end
        DONE: begin
          eng_result = eng_op + 1;
          eng_status = IDLE;
        end
        default: eng_status = IDLE;
      endcase
    end
  end

  typedef struct {
    int           id;
    logic [W-1:0] data;
    logic         err;
  } exp_t;
  exp_t sb[$];

  logic [N-1:0] req_s;
  logic         exp_err = 1'b0;
  int           ptr_m   = 0;
  always @(posedge clk) req_s <= req;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: predicts each grant from the RR model, pushes the expected
  // response, and pops/compares when the DUT answers.
  always @(negedge clk) begin
    int           w;
    logic [N-1:0] ev;
    exp_t         e;
    if (rst) begin
      sb.delete();
      ptr_m = 0;
      if (rsp_valid) check("rsp_in_reset", rsp_valid, 0);
    end else begin
      if (gnt != 0) begin
        w  = rr_pick(req_s, ptr_m);
        ev = (w < 0) ? '0 : (N'(1) << w);
        check("gnt_vec", gnt, ev);
        check("gnt_while_busy", sb.size(), 0);
        if (w >= 0) begin
          ptr_m  = (w + 1) % N;
          e.id   = w;
          e.err  = exp_err;
          e.data = exp_err ? '0 : req_data[w*W +: W] + 1;
          sb.push_back(e);
        end
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  int g_cyc = 0;
  int r_cyc = 0;

  task automatic wait_gnt(output int w);
    logic got;
    got = 1'b0;
    w   = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (gnt != 0) begin
        got   = 1'b1;
        g_cyc = cyc;
        for (int k = 0; k < N; k++) if (gnt[k]) w = k;
      end
    end
    check("gnt_seen", got, 1);
  endtask

  task automatic wait_rsp(output int lat);
    logic got;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got   = 1'b1;
        r_cyc = cyc;
        lat   = cyc - g_cyc;
      end
    end
    check("rsp_seen", got, 1);
  endtask

  task automatic one_txn(input string tag, input logic [N-1:0] r, input int exp_w, input int exp_lat);
    int w;
    int lat;
    req = r;
    wait_gnt(w);
    req = '0;
    check({tag, "_winner"}, w, exp_w);
    check({tag, "_busy"}, busy, 1);
    wait_rsp(lat);
    check({tag, "_latency"}, lat, exp_lat);
    @(negedge clk);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int w;
    int lat;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h100 * (i + 1);
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_id, rsp_data}, 0);
    check("rst_busy", busy, 0);
    check("rst_eng", {eng_enable, eng_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full contention with requests held: order 0,1,2,3,0.
    eng_lat = 1;
    exp_err = 1'b0;
    req     = '1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(w);
      check("cont_order", w, k % N);
      if (k > 0) check("cont_no_overlap", (g_cyc - r_cyc) > 0, 1);
      if (k == 4) req = '0;
      wait_rsp(lat);
      check("cont_latency", lat, 4 + 1);
    end
    @(negedge clk);

    // Single request, engine adds 1.
    eng_lat = 2;
    req_data[1*W +: W] = 32'h0000_0010;
    one_txn("single", 4'b0010, 1, 4 + 2);

    // Pointer wrap: grant 3, then 4'b1001 yields 0 before 3.
    one_txn("wrap_pre", 4'b1000, 3, 4 + 2);
    req = 4'b1001;
    wait_gnt(w);
    check("wrap_first", w, 0);
    req = 4'b1000;
    wait_rsp(lat);
    wait_gnt(w);
    check("wrap_second", w, 3);
    req = '0;
    wait_rsp(lat);
    @(negedge clk);

    // Engine stuck BUSY: timeout error, data 0.
    eng_mode = 1;
    exp_err  = 1'b1;
    one_txn("timeout", 4'b0001, 0, TO + 1);
    eng_mode = 0;
    repeat (20) @(negedge clk);

    // Engine reports ERROR.
    eng_mode = 2;
    eng_lat  = 3;
    one_txn("eng_error", 4'b0010, 1, 3 + 3);
    eng_mode = 0;
    repeat (3) @(negedge clk);

    // DONE in the same cycle the counter reaches the limit: DONE wins.
    exp_err = 1'b0;
    eng_lat = 14;
    one_txn("done_at_limit", 4'b0100, 2, 4 + 14);

    // One cycle later than the limit: timeout.
    exp_err = 1'b1;
    eng_lat = 15;
    one_txn("done_after_limit", 4'b1000, 3, TO + 1);
    repeat (5) @(negedge clk);

    // Reset in A_WAIT: outputs clear, no response, pointer back to 0.
    eng_mode = 1;
    req      = 4'b0010;
    wait_gnt(w);
    req = '0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", {gnt, rsp_valid, rsp_err, rsp_id, busy, eng_enable}, 0);
    check("midrst_data", {rsp_data, eng_data}, 0);
    @(negedge clk);
    eng_mode = 0;
    eng_lat  = 1;
    exp_err  = 1'b0;
    rst      = 1'b0;
    req      = '1;
    wait_gnt(w);
    check("post_rst_first", w, 0);
    req = '0;
    wait_rsp(lat);
    check("post_rst_latency", lat, 4 + 1);
    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
